// File: rtl/vram_arbiter_pkg.sv
// Package: vram_arbiter_pkg
// Shared constants and helpers for the VRAM arbiter slice.
//   ARB_MODE_RR    : round-robin arbitration, search starts after the last grant
//   ARB_MODE_FIXED : fixed priority, lowest client index wins
//   idx_width()    : width of a client index / read tag (at least 1 bit)
package vram_arbiter_pkg;

    localparam int ARB_MODE_RR    = 0;
    localparam int ARB_MODE_FIXED = 1;

    // Width needed to hold a client index 0..n-1; never narrower than one bit
    // so a two-client build still has a usable tag.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/vram_arbiter_rr_priority_picker.sv
// Module: vram_arbiter_rr_priority_picker
// Circular priority picker: scans eligible[] starting at index 'start',
// wrapping N-1 -> 0, and returns the first eligible client.
// Fixed-priority arbitration uses the same picker with start = 0.
// Ports:
//   eligible   in  N    per-client eligibility this cycle
//   start      in  IW   index where the search begins
//   pick       out N    one-hot winner (all zero when nothing is eligible)
//   pick_idx   out IW   index of the winner (0 when nothing is eligible)
//   pick_valid out 1    a winner exists
module vram_arbiter_rr_priority_picker
    import vram_arbiter_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = idx_width(N)
) (
    input  logic [N-1:0]  eligible,
    input  logic [IW-1:0] start,
    output logic [N-1:0]  pick,
    output logic [IW-1:0] pick_idx,
    output logic          pick_valid
);

    always_comb begin
        int idx;
        idx        = 0;
        pick       = '0;
        pick_idx   = '0;
        pick_valid = 1'b0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(start) + k) % N;
            if (!pick_valid && eligible[idx]) begin
                pick_valid = 1'b1;
                pick[idx]  = 1'b1;
                pick_idx   = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/vram_arbiter.sv
// Module: vram_arbiter
// N-client VRAM arbiter. Issues at most one VRAM access per cycle, chosen by
// round-robin or fixed priority, with burst lock (bounded by MAX_HOLD) and an
// MPU override that restricts eligibility to client 0. Read data is routed
// back to the issuing client through a tag pipeline.
//
// Handshake: a client raises req (with wr/be/addr/wdata stable) and holds it
// until it sees gnt; gnt is combinational in the same cycle and means the
// command was accepted. The command appears on the vram_* pins one cycle later.
// A read returns rvalid[client] for one cycle READ_LATENCY+2 cycles after gnt.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   mpu_override          only client 0 is eligible while high
//   req/lock/wr           per-client request, lock, write (1) / read (0)
//   be/addr/wdata         packed per-client byte enables, word address, data
//   gnt                   one-hot accept (combinational, 0 during reset)
//   rvalid/rdata          one-cycle read return strobe and shared read data
//   vram_en/rd/wr/be      registered VRAM command strobes
//   vram_addr/data_out    registered VRAM address and write data
//   vram_data_in          read data from VRAM, valid READ_LATENCY after command
module vram_arbiter
    import vram_arbiter_pkg::*;
#(
    parameter int NUM_CLIENTS  = 4,
    parameter int ADDR_WIDTH   = 20,
    parameter int DATA_WIDTH   = 16,
    parameter int READ_LATENCY = 1,
    parameter int ARB_MODE     = ARB_MODE_RR,
    parameter int MAX_HOLD     = 8
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              mpu_override,
    input  logic [NUM_CLIENTS-1:0]            req,
    input  logic [NUM_CLIENTS-1:0]            lock,
    input  logic [NUM_CLIENTS-1:0]            wr,
    input  logic [2*NUM_CLIENTS-1:0]          be,
    input  logic [NUM_CLIENTS*ADDR_WIDTH-1:0] addr,
    input  logic [NUM_CLIENTS*DATA_WIDTH-1:0] wdata,
    output logic [NUM_CLIENTS-1:0]            gnt,
    output logic [NUM_CLIENTS-1:0]            rvalid,
    output logic [DATA_WIDTH-1:0]             rdata,
    output logic                              vram_en,
    output logic                              vram_rd,
    output logic                              vram_wr,
    output logic [1:0]                        vram_be,
    output logic [ADDR_WIDTH-1:0]             vram_addr,
    output logic [DATA_WIDTH-1:0]             vram_data_out,
    input  logic [DATA_WIDTH-1:0]             vram_data_in
);

    localparam int N  = NUM_CLIENTS;
    localparam int IW = idx_width(N);
    localparam int HW = $clog2(MAX_HOLD + 1);
    localparam logic [N-1:0] ONE = N'(1);

    logic [N-1:0]  base_elig;
    logic [N-1:0]  elig;
    logic [N-1:0]  pick;
    logic [IW-1:0] pick_idx;
    logic          pick_valid;
    logic [IW-1:0] start_idx;

    logic [IW-1:0] last_idx;        // round-robin pointer: last granted client
    logic          prev_gnt_valid;  // a grant was issued in the previous cycle
    logic [HW-1:0] hold_cnt;        // consecutive grants to the current client
    logic [HW-1:0] hold_next;

    logic          holder_locked;
    logic          hold_expired;
    logic          lock_keep;

    logic          g_valid;
    logic [IW-1:0] g_idx;
    logic [N-1:0]  g_onehot;
    logic          g_wr;

    logic          tag_valid [READ_LATENCY+1];
    logic [IW-1:0] tag_idx   [READ_LATENCY+1];

    // Override applies to the current-cycle value, so a request arriving in
    // the same cycle the override changes is judged against the new setting.
    always_comb begin
        base_elig = req;
        if (mpu_override) begin
            base_elig = req & ONE;
        end
    end

    // The previous holder keeps the bus while it locks and is still eligible;
    // under override a non-zero holder is ineligible, which breaks the lock.
    assign holder_locked = prev_gnt_valid & lock[last_idx] & base_elig[last_idx];
    assign hold_expired  = holder_locked & (hold_cnt >= HW'(MAX_HOLD));
    assign lock_keep     = holder_locked & ~hold_expired;

    // A holder that used up its hold budget sits out exactly one arbitration.
    always_comb begin
        elig = base_elig;
        if (hold_expired) begin
            elig[last_idx] = 1'b0;
        end
    end

    always_comb begin
        start_idx = '0;
        if (ARB_MODE == ARB_MODE_RR && last_idx != IW'(N - 1)) begin
            start_idx = last_idx + 1'b1;
        end
    end

    vram_arbiter_rr_priority_picker #(
        .N  (N),
        .IW (IW)
    ) u_picker (
        .eligible   (elig),
        .start      (start_idx),
        .pick       (pick),
        .pick_idx   (pick_idx),
        .pick_valid (pick_valid)
    );

    always_comb begin
        if (lock_keep) begin
            g_valid  = 1'b1;
            g_idx    = last_idx;
            g_onehot = ONE << last_idx;
        end else begin
            g_valid  = pick_valid;
            g_idx    = pick_idx;
            g_onehot = pick;
        end
    end

    assign gnt  = reset ? '0 : g_onehot;
    assign g_wr = wr[g_idx];

    // Counts the current client's consecutive grants, starting at 1 on a new
    // grant; saturates at MAX_HOLD and clears when no grant is issued.
    always_comb begin
        hold_next = '0;
        if (g_valid) begin
            if (lock_keep) begin
                hold_next = (hold_cnt == HW'(MAX_HOLD)) ? hold_cnt : hold_cnt + 1'b1;
            end else begin
                hold_next = HW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_idx       <= IW'(N - 1);
            prev_gnt_valid <= 1'b0;
            hold_cnt       <= '0;
            vram_en        <= 1'b0;
            vram_rd        <= 1'b0;
            vram_wr        <= 1'b0;
            vram_be        <= '0;
            vram_addr      <= '0;
            vram_data_out  <= '0;
            rvalid         <= '0;
            rdata          <= '0;
            for (int k = 0; k <= READ_LATENCY; k++) begin
                tag_valid[k] <= 1'b0;
                tag_idx[k]   <= '0;
            end
        end else begin
            prev_gnt_valid <= g_valid;
            hold_cnt       <= hold_next;
            if (g_valid) begin
                last_idx <= g_idx;
            end

            vram_en <= g_valid;
            vram_rd <= g_valid & ~g_wr;
            vram_wr <= g_valid & g_wr;
            vram_be <= g_valid ? be[2*g_idx +: 2] : 2'b00;
            if (g_valid) begin
                vram_addr     <= addr[g_idx*ADDR_WIDTH +: ADDR_WIDTH];
                vram_data_out <= wdata[g_idx*DATA_WIDTH +: DATA_WIDTH];
            end

            // Stage k holds the tag of the read whose command was on the pins
            // k cycles ago; the last stage lines up with valid vram_data_in.
            tag_valid[0] <= g_valid & ~g_wr;
            tag_idx[0]   <= g_idx;
            for (int k = 1; k <= READ_LATENCY; k++) begin
                tag_valid[k] <= tag_valid[k-1];
                tag_idx[k]   <= tag_idx[k-1];
            end

            rvalid <= tag_valid[READ_LATENCY] ? (ONE << tag_idx[READ_LATENCY]) : '0;
            if (tag_valid[READ_LATENCY]) begin
                rdata <= vram_data_in;
            end
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// Testbench for vram_arbiter: a round-robin instance (scoreboarded) and a
// fixed-priority instance sharing the same stimulus.
module tb_vram_arbiter;

    localparam int N  = 4;
    localparam int AW = 20;
    localparam int DW = 16;
    localparam int RL = 1;
    localparam int IW = 2;
    localparam int W  = IW + DW;

    // ---------------- clock / reset ----------------
    logic clk;
    logic reset;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- stimulus / DUT signals ----------------
    logic            mpu_override;
    logic [N-1:0]    req, lock, wr;
    logic [2*N-1:0]  be;
    logic [N*AW-1:0] addr;
    logic [N*DW-1:0] wdata;
    logic [DW-1:0]   vram_data_in;

    logic [N-1:0]  rr_gnt, rr_rvalid, fx_gnt, fx_rvalid;
    logic [DW-1:0] rr_rdata, fx_rdata, rr_vram_data_out, fx_vram_data_out;
    logic          rr_vram_en, rr_vram_rd, rr_vram_wr;
    logic          fx_vram_en, fx_vram_rd, fx_vram_wr;
    logic [1:0]    rr_vram_be, fx_vram_be;
    logic [AW-1:0] rr_vram_addr, fx_vram_addr;

    vram_arbiter #(
        .NUM_CLIENTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
        .READ_LATENCY(RL), .ARB_MODE(0), .MAX_HOLD(4)
    ) dut_rr (
        .clk(clk), .reset(reset), .mpu_override(mpu_override),
        .req(req), .lock(lock), .wr(wr), .be(be), .addr(addr), .wdata(wdata),
        .gnt(rr_gnt), .rvalid(rr_rvalid), .rdata(rr_rdata),
        .vram_en(rr_vram_en), .vram_rd(rr_vram_rd), .vram_wr(rr_vram_wr),
        .vram_be(rr_vram_be), .vram_addr(rr_vram_addr),
        .vram_data_out(rr_vram_data_out), .vram_data_in(vram_data_in)
    );

    vram_arbiter #(
        .NUM_CLIENTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
        .READ_LATENCY(RL), .ARB_MODE(1), .MAX_HOLD(4)
    ) dut_fx (
        .clk(clk), .reset(reset), .mpu_override(mpu_override),
        .req(req), .lock(lock), .wr(wr), .be(be), .addr(addr), .wdata(wdata),
        .gnt(fx_gnt), .rvalid(fx_rvalid), .rdata(fx_rdata),
        .vram_en(fx_vram_en), .vram_rd(fx_vram_rd), .vram_wr(fx_vram_wr),
        .vram_be(fx_vram_be), .vram_addr(fx_vram_addr),
        .vram_data_out(fx_vram_data_out), .vram_data_in(vram_data_in)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // VRAM contents as the bench sees them
    function automatic logic [DW-1:0] mem_val(input logic [AW-1:0] a);
        if (a == 20'h00123) return 16'hBEEF;
        return a[DW-1:0] ^ 16'h5A5A;
    endfunction

    // VRAM model: a read on the pins in cycle c returns data during c+RL
    logic          rd_prev;
    logic [AW-1:0] addr_prev;
    initial begin
        rd_prev      = 1'b0;
        addr_prev    = '0;
        vram_data_in = '0;
    end
    always @(negedge clk) begin
        vram_data_in = rd_prev ? mem_val(addr_prev) : '0;
        rd_prev      = rr_vram_rd;
        addr_prev    = rr_vram_addr;
    end

    // ---------------- scoreboard ----------------
    logic [W-1:0]  exp_q[$];
    logic [W-1:0]  e;
    logic          pend_valid;
    logic          pend_wr;
    logic [AW-1:0] pend_addr;

    initial pend_valid = 1'b0;

    always @(negedge clk) begin
        if (reset) begin
            pend_valid = 1'b0;
        end else begin
            if (pend_valid) begin
                check("cmd_en", rr_vram_en, 1);
                check("cmd_rd", rr_vram_rd, !pend_wr);
                check("cmd_wr", rr_vram_wr, pend_wr);
                check("cmd_addr", rr_vram_addr, pend_addr);
            end else begin
                check("idle_en", {rr_vram_en, rr_vram_rd, rr_vram_wr}, 0);
            end
            check("gnt_onehot0", $onehot0(rr_gnt), 1);
            check("gnt_subset", rr_gnt & ~req, 0);
            pend_valid = 1'b0;
            for (int i = 0; i < N; i++) begin
                if (rr_gnt[i]) begin
                    pend_valid = 1'b1;
                    pend_wr    = wr[i];
                    pend_addr  = addr[i*AW +: AW];
                    if (!wr[i]) exp_q.push_back({IW'(i), mem_val(addr[i*AW +: AW])});
                end
            end
            if (rr_rvalid != '0) begin
                if (exp_q.size() == 0) begin
                    check("rvalid_spurious", rr_rvalid, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("rvalid_client", rr_rvalid, 32'(4'b0001 << e[W-1:DW]));
                    check("rdata", rr_rdata, e[DW-1:0]);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cyc(input logic [N-1:0] r, input logic [N-1:0] l, input logic [N-1:0] w);
        @(posedge clk); #1;
        req  = r;
        lock = l;
        wr   = w;
        @(negedge clk);
    endtask

    logic [N-1:0] served;
    logic [N-1:0] exp_lock [6];

    initial begin
        reset        = 1'b1;
        mpu_override = 1'b0;
        req          = 4'b1111;
        lock         = '0;
        wr           = 4'b1111;
        be           = '1;
        addr         = '0;
        wdata        = '0;

        // reset state with requests pending
        repeat (2) @(negedge clk);
        check("rst_gnt", rr_gnt, 0);
        check("rst_en", {rr_vram_en, rr_vram_rd, rr_vram_wr}, 0);
        check("rst_rvalid", rr_rvalid, 0);
        check("rst_rdata", rr_rdata, 0);
        check("rst_fx_gnt", fx_gnt, 0);

        // round-robin rotation with all clients requesting
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("rr_seq0", rr_gnt, 4'b0001);
        check("fx_seq0", fx_gnt, 4'b0001);
        for (int k = 1; k < 5; k++) begin
            cyc(4'b1111, 4'b0000, 4'b1111);
            check("rr_seq", rr_gnt, 32'(4'b0001 << (k % 4)));
            check("fx_seq", fx_gnt, 4'b0001);
        end

        // fixed priority: client 3 starves
        for (int k = 0; k < 4; k++) begin
            cyc(4'b1010, 4'b0000, 4'b1010);
            check("fx_starve", fx_gnt, 4'b0010);
        end
        repeat (4) cyc(4'b0000, 4'b0000, 4'b0000);

        // single read: command at t+1, data at t+2, return at t+3
        addr[2*AW +: AW] = 20'h00123;
        cyc(4'b0100, 4'b0000, 4'b0000);
        check("rd_gnt", rr_gnt, 4'b0100);
        cyc(4'b0000, 4'b0000, 4'b0000);
        check("rd_vram_addr", rr_vram_addr, 20'h00123);
        check("rd_vram_rd", rr_vram_rd, 1);
        cyc(4'b0000, 4'b0000, 4'b0000);
        check("rd_early_rvalid", rr_rvalid, 0);
        cyc(4'b0000, 4'b0000, 4'b0000);
        check("rd_rvalid", rr_rvalid, 4'b0100);
        check("rd_rdata", rr_rdata, 16'hBEEF);

        // random traffic; requests held until granted
        served = '0;
        for (int c = 0; c < 80; c++) begin
            @(posedge clk); #1;
            for (int i = 0; i < N; i++) begin
                if (!req[i] || served[i]) begin
                    req[i]            = ($urandom_range(0, 3) != 0);
                    wr[i]             = 1'($urandom_range(0, 1));
                    lock[i]           = ($urandom_range(0, 3) == 0);
                    be[2*i +: 2]      = 2'($urandom_range(1, 3));
                    addr[i*AW +: AW]  = 20'($urandom_range(0, 20'hFFFFF));
                    wdata[i*DW +: DW] = 16'($urandom_range(0, 16'hFFFF));
                end
            end
            @(negedge clk);
            served = rr_gnt;
        end
        repeat (6) cyc(4'b0000, 4'b0000, 4'b0000);
        check("drain_random", exp_q.size(), 0);

        // lock with hold limit 4: 1,1,1,1,3,1,1
        cyc(4'b0010, 4'b0010, 4'b1010);
        check("lock_first", rr_gnt, 4'b0010);
        check("lock_first_fx", fx_gnt, 4'b0010);
        exp_lock = '{4'b0010, 4'b0010, 4'b0010, 4'b1000, 4'b0010, 4'b0010};
        for (int k = 0; k < 6; k++) begin
            cyc(4'b1010, 4'b0010, 4'b1010);
            check("lock_rr", rr_gnt, exp_lock[k]);
            check("lock_fx", fx_gnt, exp_lock[k]);
        end

        // override breaks a lock held by client 1, then masks clients 1..3
        cyc(4'b0010, 4'b0010, 4'b1111);
        check("ovr_pre", rr_gnt, 4'b0010);
        @(posedge clk); #1;
        mpu_override = 1'b1;
        req = 4'b0011; lock = 4'b0011; wr = 4'b1111;
        @(negedge clk);
        check("ovr_break", rr_gnt, 4'b0001);
        cyc(4'b0110, 4'b0000, 4'b1111);
        check("ovr_mask_a", rr_gnt, 0);
        cyc(4'b0110, 4'b0000, 4'b1111);
        check("ovr_mask_b", rr_gnt, 0);
        addr[0 +: AW] = 20'h00456;
        cyc(4'b0111, 4'b0000, 4'b1110);
        check("ovr_c0", rr_gnt, 4'b0001);

        // reset while that read is outstanding
        @(posedge clk); #1;
        reset = 1'b1;
        req   = 4'b1111;
        #1;
        check("mid_rst_en", {rr_vram_en, rr_vram_rd, rr_vram_wr}, 0);
        check("mid_rst_rvalid", rr_rvalid, 0);
        check("mid_rst_rdata", rr_rdata, 0);
        check("mid_rst_gnt", rr_gnt, 0);
        exp_q.delete();
        @(negedge clk);
        check("mid_rst_gnt_hold", rr_gnt, 0);
        @(posedge clk); #1;
        reset        = 1'b0;
        mpu_override = 1'b0;
        req          = 4'b0000;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("post_rst_rvalid", rr_rvalid, 0);
        end
        check("drain_final", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
